// File: rtl/cpl1_decode_serial_pkg.sv
// Shared constants for the serial ones'-complement to sign-magnitude decoder.
package cpl1_decode_serial_pkg;

  localparam int W_DEF = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CORR = 2'd1;
  localparam logic [1:0] CONV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/cpl1_decode_serial_invert.sv
// W-bit conditional inverter: result = data when inv=0, ~data when inv=1.
module cpl_invert_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] data,
  input  logic         inv,
  output logic [W-1:0] result
);

  assign result = data ^ {W{inv}};

endmodule

// File: rtl/cpl1_decode_serial.sv
// Bit-serial end-around-carry correction of a ones'-complement sum, then sign/magnitude decode.
// Handshake: a word transfers on a rising edge where valid and ready are both high; one word in flight.
module cpl1_decode_serial
  import cpl1_decode_serial_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_mag,
  output logic         out_sign,
  output logic         out_negzero
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  logic [1:0]    state;
  logic [W-1:0]  sh;
  logic          c;
  logic [CW-1:0] cnt;
  logic          sum;
  logic          allones;
  logic [W-1:0]  mag;

  assign in_ready = (state == IDLE);
  assign sum      = sh[0] ^ c;
  assign allones  = &sh;

  // Negative words (MSB set) are flipped to recover the magnitude.
  cpl_invert_w #(.W(W)) u_invert (
    .data   (sh),
    .inv    (sh[W-1]),
    .result (mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh          <= '0;
      c           <= 1'b0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_mag     <= '0;
      out_sign    <= 1'b0;
      out_negzero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_data;
            c     <= in_cout;
            cnt   <= '0;
            state <= CORR;
          end
        end
        CORR: begin
          // LSB-first ripple: the carry out of the MSB is dropped, so all-ones plus one wraps to zero.
          sh  <= {sum, sh[W-1:1]};
          c   <= sh[0] & c;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= CONV;
        end
        CONV: begin
          out_sign    <= sh[W-1] & ~allones;
          out_mag     <= mag;
          out_negzero <= allones;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpl1_decode_serial.sv
// Directed bench for cpl1_decode_serial with a result scoreboard fed at input acceptance.
module tb_cpl1_decode_serial;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_mag;
  logic         out_sign;
  logic         out_negzero;

  int checks = 0;
  int errors = 0;

  logic [W+1:0] exp_q[$];

  cpl1_decode_serial #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_cout     (in_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mag     (out_mag),
    .out_sign    (out_sign),
    .out_negzero (out_negzero)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: add carry mod 2^W, then decode {negzero, sign, mag}.
  function automatic logic [W+1:0] model(input logic [W-1:0] d, input logic c);
    logic [W-1:0] corr;
    logic         ao;
    logic         sg;
    logic [W-1:0] m;
    corr = d + {{(W-1){1'b0}}, c};
    ao   = (corr == {W{1'b1}});
    sg   = corr[W-1] && !ao;
    m    = corr[W-1] ? ~corr : corr;
    return {ao, sg, m};
  endfunction

  // Scoreboard: compare on each output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        check("result", 32'({out_negzero, out_sign, out_mag}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [W-1:0] d, input logic c);
    int k;
    in_data  = d;
    in_cout  = c;
    in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("send_ready_timeout", 32'(k < 50), 32'd1);
    exp_q.push_back(model(d, c));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom_range(0, (1 << W) - 1));
    in_cout  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int gap;
    logic [W+1:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cout   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs",   32'({out_negzero, out_sign, out_mag}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 5 + (-2), with latency measured from the accepting edge
    send(4'b0010, 1'b1);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      if (!out_valid) lat++;
    end
    check("latency", 32'(lat), 32'(W + 1));
    check("pos_mag", 32'(out_mag), 32'h3);
    check("pos_sign", 32'(out_sign), 32'd0);
    drain();

    send(4'b1100, 1'b0);
    drain();
    check("neg_mag", 32'(out_mag), 32'h3);
    check("neg_sign", 32'(out_sign), 32'd1);

    send(4'b1111, 1'b0);
    drain();
    check("negzero_flag", 32'(out_negzero), 32'd1);
    send(4'b1111, 1'b1);
    drain();
    check("wrap_negzero", 32'(out_negzero), 32'd0);
    send(4'b0111, 1'b0);
    send(4'b1000, 1'b1);
    drain();

    // Backpressure: hold result for 5 cycles, in_valid pulse must be ignored
    out_ready = 1'b0;
    send(4'b1010, 1'b1);
    for (int k = 0; k < 30 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    held = {out_negzero, out_sign, out_mag};
    check("bp_value", 32'(held), 32'(model(4'b1010, 1'b1)));
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        in_data  = 4'b0001;
        in_cout  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_data_hold", 32'({out_negzero, out_sign, out_mag}), 32'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_sticky", 32'({out_negzero, out_sign, out_mag}), 32'(held));
    repeat (W + 3) @(posedge clk);
    #1;
    check("bp_pulse_ignored", 32'(out_valid), 32'd0);
    check("bp_queue", 32'(exp_q.size()), 32'd0);

    // Reset two steps into correction
    send(4'b1001, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'b0110, 1'b0);
    drain();
    check("post_reset_mag", 32'(out_mag), 32'h6);
    check("post_reset_sign", 32'(out_sign), 32'd0);

    // Back-to-back with in_valid held high
    send(4'b0010, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'b1100;
    in_cout  = 1'b0;
    gap = 0;
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      if (in_ready) begin
        gap = k;
        break;
      end
    end
    check("b2b_gap", 32'(gap), 32'(W + 3));
    exp_q.push_back(model(4'b1100, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    check("b2b_last_sign", 32'(out_sign), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
